// File: rtl/cam_i2c_responder.sv
// I2C/SCCB camera-register target: 7-bit device address, 16-bit register pointer, 8-bit data, small register file.
// Optional build macro CAM_RESP_GLITCH_FILTER_EN inserts a 3-sample hold filter on SCL/SDA after the synchronizers.
module cam_i2c_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'h36,
    parameter int         AW        = 5,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic        bit_clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_stb,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REGH, REGH_ACK, REGL, REGL_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    logic [1:0]  scl_sync, sda_sync;
    logic        scl_f, sda_f;
    logic        scl_d, scl_q, sda_d, sda_q;
    logic        scl_rise, scl_fall, start_c, stop_c;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  regh, regh_n;
    logic [15:0] pointer, pointer_n, ptr_inc;
    logic        master_nack, master_nack_n;
    logic        sda_oe_n, wr_stb_n;
    logic [15:0] wr_addr_n;
    logic [7:0]  wr_data_n;
    logic        mem_we;
    logic [7:0]  mem [0:DEPTH-1];
    logic [7:0]  rd_cur, rd_next;

    // Synchronizers reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge bit_clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef CAM_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    // A level is accepted only after three identical consecutive samples.
    always_ff @(posedge bit_clk) begin
        if (reset) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if (scl_hist == {2{scl_sync[1]}})
                scl_filt <= scl_sync[1];
            if (sda_hist == {2{sda_sync[1]}})
                sda_filt <= sda_sync[1];
        end
    end

    assign scl_f = scl_filt;
    assign sda_f = sda_filt;
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge bit_clk) begin
        if (reset) begin
            scl_d <= 1'b1;
            scl_q <= 1'b1;
            sda_d <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_d <= scl_f;
            scl_q <= scl_d;
            sda_d <= sda_f;
            sda_q <= sda_d;
        end
    end

    assign scl_rise = scl_d & ~scl_q;
    assign scl_fall = ~scl_d & scl_q;
    assign start_c  = scl_d & scl_q & sda_q & ~sda_d;
    assign stop_c   = scl_d & scl_q & ~sda_q & sda_d;

    assign ptr_inc = pointer + 16'd1;
    assign rd_cur  = mem[pointer[AW-1:0]];
    assign rd_next = mem[ptr_inc[AW-1:0]];
    assign busy    = (state != IDLE);

    always_ff @(posedge bit_clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 8'd0;
            regh        <= 8'd0;
            pointer     <= 16'd0;
            master_nack <= 1'b0;
            sda_oe      <= 1'b0;
            wr_stb      <= 1'b0;
            wr_addr     <= 16'd0;
            wr_data     <= 8'd0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            regh        <= regh_n;
            pointer     <= pointer_n;
            master_nack <= master_nack_n;
            sda_oe      <= sda_oe_n;
            wr_stb      <= wr_stb_n;
            wr_addr     <= wr_addr_n;
            wr_data     <= wr_data_n;
        end
    end

    // SDA is only ever changed on a detected SCL falling edge, so it stays stable while SCL is high.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        regh_n        = regh;
        pointer_n     = pointer;
        master_nack_n = master_nack;
        sda_oe_n      = sda_oe;
        wr_stb_n      = 1'b0;
        wr_addr_n     = wr_addr;
        wr_data_n     = wr_data;
        mem_we        = 1'b0;

        if (start_c) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else if (stop_c) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR, REGH, REGL, WDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift[6:0], sda_d};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_n = 1'b1;
                        case (state)
                            ADDR: begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state_n = ADDR_ACK;
                                end else begin
                                    state_n  = IDLE;
                                    sda_oe_n = 1'b0;
                                end
                            end
                            REGH: begin
                                state_n = REGH_ACK;
                                regh_n  = shift;
                            end
                            REGL:    state_n = REGL_ACK;
                            default: state_n = WDATA_ACK;
                        endcase
                    end
                end
                // The falling edge seen in an ACK state always follows the 9th rising edge.
                ADDR_ACK, REGH_ACK, REGL_ACK, WDATA_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_n = 4'd0;
                    end else if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        case (state)
                            ADDR_ACK: begin
                                if (shift[0]) begin
                                    state_n  = RDATA;
                                    shift_n  = rd_cur;
                                    sda_oe_n = ~rd_cur[7];
                                end else begin
                                    state_n = REGH;
                                end
                            end
                            REGH_ACK: state_n = REGL;
                            REGL_ACK: begin
                                state_n   = WDATA;
                                pointer_n = {regh, shift};
                            end
                            default: begin
                                state_n   = WDATA;
                                mem_we    = 1'b1;
                                wr_stb_n  = 1'b1;
                                wr_addr_n = pointer;
                                wr_data_n = shift;
                                pointer_n = ptr_inc;
                            end
                        endcase
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n  = RDATA_ACK;
                            sda_oe_n = 1'b0;
                        end else begin
                            sda_oe_n = ~shift[7];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_n     = 4'd0;
                        master_nack_n = sda_d;
                    end else if (scl_fall) begin
                        if (master_nack) begin
                            state_n  = IDLE;
                            sda_oe_n = 1'b0;
                        end else begin
                            state_n   = RDATA;
                            pointer_n = ptr_inc;
                            shift_n   = rd_next;
                            sda_oe_n  = ~rd_next[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge bit_clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= RESET_VAL;
        end else if (mem_we) begin
            mem[pointer[AW-1:0]] <= shift;
        end
    end
endmodule

// File: tb/tb_cam_i2c_responder.sv
// Bench for cam_i2c_responder: bit-banged I2C master, transaction-level register model, write-strobe scoreboard.
module tb_cam_i2c_responder;
    localparam logic [6:0] DEV = 7'h36;
    localparam int Q = 8;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        bit_clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic        glitch = 1'b0;
    logic        scl_in, sda_in;
    logic        sda_oe, wr_stb, busy;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_mem [0:31];
    logic [15:0] model_ptr = 16'd0;
    wr_t         exp_q[$];
    logic        sda_oe_seen = 1'b0;

    assign scl_in = scl_drv | glitch;
    assign sda_in = sda_drv & ~sda_oe;

    cam_i2c_responder dut (
        .bit_clk(bit_clk),
        .reset  (reset),
        .scl_in (scl_in),
        .sda_in (sda_in),
        .sda_oe (sda_oe),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy   (busy)
    );

    always #5 bit_clk = ~bit_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge bit_clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One SCL period; entered and left with SCL just driven low.
    task automatic bit_cycle(input logic b, input bit glitch_it, output logic sampled);
        if (glitch_it) begin
            tick(Q / 2);
            glitch = 1'b1;
            tick(1);
            glitch = 1'b0;
            tick(Q / 2 - 1);
        end else begin
            tick(Q);
        end
        sda_drv = b;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        sampled = sda_in;
        tick(Q);
        scl_drv = 1'b0;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        sda_drv = 1'b0;
        tick(Q);
        scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q);
        sda_drv = 1'b0;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        sda_drv = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch_it, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--)
            bit_cycle(b[i], glitch_it && (i == 3), s);
        bit_cycle(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_cycle(give_ack ? 1'b0 : 1'b1, 1'b0, s);
    endtask

    // One complete transaction; the model and the expected-strobe queue are updated as bytes are issued.
    task automatic applyStimulus(input bit do_read, input bit set_ptr, input logic [15:0] addr,
                                 input int nbytes, input logic [31:0] wdata, input bit glitch_it);
        logic       ack;
        logic [7:0] d, rd, exp_rd;
        i2c_start();
        checkOutput("busy after START", 32'(busy), 32'd1);
        if (!do_read || set_ptr) begin
            write_byte({DEV, 1'b0}, 1'b0, ack);
            checkOutput("ACK device write address", 32'(ack), 32'd1);
            write_byte(addr[15:8], 1'b0, ack);
            checkOutput("ACK register high", 32'(ack), 32'd1);
            write_byte(addr[7:0], 1'b0, ack);
            checkOutput("ACK register low", 32'(ack), 32'd1);
            model_ptr = addr;
        end
        if (!do_read) begin
            for (int i = 0; i < nbytes; i++) begin
                d = wdata[8*i +: 8];
                exp_q.push_back({model_ptr, d});
                model_mem[model_ptr[4:0]] = d;
                model_ptr = model_ptr + 16'd1;
                write_byte(d, glitch_it, ack);
                checkOutput("ACK data byte", 32'(ack), 32'd1);
            end
        end else begin
            if (set_ptr)
                i2c_start();
            write_byte({DEV, 1'b1}, 1'b0, ack);
            checkOutput("ACK device read address", 32'(ack), 32'd1);
            for (int i = 0; i < nbytes; i++) begin
                exp_rd = model_mem[model_ptr[4:0]];
                read_byte(i != nbytes - 1, rd);
                checkOutput("read data", 32'(rd), 32'(exp_rd));
                if (i != nbytes - 1)
                    model_ptr = model_ptr + 16'd1;
            end
        end
        i2c_stop();
        checkOutput("busy after STOP", 32'(busy), 32'd0);
    endtask

    // Monitor: every write strobe must match the oldest expected write and last a single cycle.
    initial begin
        logic prev_stb;
        wr_t  e;
        prev_stb = 1'b0;
        forever begin
            @(negedge bit_clk);
            if (sda_oe)
                sda_oe_seen = 1'b1;
            if (wr_stb) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wr_stb unexpected: got addr 0x%h data 0x%h, expected no strobe", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (prev_stb || wr_addr !== e.a || wr_data !== e.d) begin
                        errors++;
                        $display("[TB] FAIL wr_stb: got addr 0x%h data 0x%h (prev_stb %0b), expected addr 0x%h data 0x%h (prev_stb 0)",
                                 wr_addr, wr_data, prev_stb, e.a, e.d);
                    end
                end
            end
            prev_stb = wr_stb;
        end
    end

    initial begin
        repeat (95000) @(posedge bit_clk);
        $display("[TB] FAIL watchdog: got no completion, expected finish within 95000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        ack;
        logic [15:0] ra;
        logic [31:0] rd_word;
        int          kind, n;

        for (int i = 0; i < 32; i++)
            model_mem[i] = 8'h00;

        tick(4);
        checkOutput("reset sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset wr_stb", 32'(wr_stb), 32'd0);
        checkOutput("reset wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset wr_data", 32'(wr_data), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(4);

        $display("[TB] single register write");
        applyStimulus(1'b0, 1'b0, 16'h0100, 1, 32'h01, 1'b0);

        $display("[TB] burst write and repeated-START readback");
        applyStimulus(1'b0, 1'b0, 16'h3034, 2, 32'h211A, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h3034, 2, 32'h0, 1'b0);

        $display("[TB] foreign device address");
        sda_oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h50, 1'b0, ack);
        checkOutput("no ACK foreign address", 32'(ack), 32'd0);
        write_byte(8'h12, 1'b0, ack);
        checkOutput("no ACK following byte", 32'(ack), 32'd0);
        i2c_stop();
        checkOutput("sda_oe never asserted", 32'(sda_oe_seen), 32'd0);
        checkOutput("busy after foreign STOP", 32'(busy), 32'd0);

        $display("[TB] pointer wrap");
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 2, 32'hBBAA, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 2, 32'h0, 1'b0);

        $display("[TB] reset during read");
        applyStimulus(1'b0, 1'b0, 16'h0005, 1, 32'h3C, 1'b0);
        i2c_start();
        write_byte({DEV, 1'b0}, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        write_byte(8'h05, 1'b0, ack);
        i2c_start();
        write_byte({DEV, 1'b1}, 1'b0, ack);
        checkOutput("ACK read before reset", 32'(ack), 32'd1);
        tick(12);
        checkOutput("read MSB driven low", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        checkOutput("sda_oe after reset", 32'(sda_oe), 32'd0);
        checkOutput("busy after reset", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++)
            model_mem[i] = 8'h00;
        model_ptr = 16'd0;
        tick(2);
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        tick(2 * Q);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h1234, 2, 32'hC3E7, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h1234, 2, 32'h0, 1'b0);

`ifdef CAM_RESP_GLITCH_FILTER_EN
        $display("[TB] SCL glitch during data byte");
        applyStimulus(1'b0, 1'b0, 16'h0042, 1, 32'h5A, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0042, 1, 32'h0, 1'b0);
`else
        $display("[TB] glitch case skipped: filter not built in");
`endif

        $display("[TB] randomized transactions");
        for (int t = 0; t < 10; t++) begin
            kind    = int'($urandom_range(0, 2));
            n       = int'($urandom_range(1, 3));
            ra      = 16'($urandom);
            rd_word = $urandom;
            case (kind)
                0:       applyStimulus(1'b0, 1'b0, ra, n, rd_word, 1'b0);
                1:       applyStimulus(1'b1, 1'b1, ra, n, 32'h0, 1'b0);
                default: applyStimulus(1'b1, 1'b0, ra, n, 32'h0, 1'b0);
            endcase
        end

        tick(40);
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
